// File: rtl/divekick_pkg.sv
`default_nettype none
// ============================================================================
// Package     : divekick_pkg
// Description : Shared types, geometry defaults and box helpers for the
//               DiveKick hit/health/round logic.
// Revision    : 1.0 - initial release
// ============================================================================
package divekick_pkg;

  typedef enum logic [2:0] {
    STAND   = 3'd0,
    JUMP    = 3'd1,
    KICK_R  = 3'd2,
    STAND_L = 3'd3,
    JUMP_L  = 3'd4,
    KICK_L  = 3'd5
  } fighter_state_e;

  typedef struct packed {
    logic [10:0] x0;
    logic [10:0] y0;
    logic [10:0] x1;
    logic [10:0] y1;
  } box_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_DRAW = 2'd3
  } winner_e;

  typedef enum logic [1:0] {
    ST_FIGHT      = 2'd0,
    ST_FREEZE     = 2'd1,
    ST_ROUND_OVER = 2'd2
  } round_state_e;

  localparam int unsigned c_FIGHTER_W     = 72;
  localparam int unsigned c_FIGHTER_H     = 105;
  localparam int unsigned c_KICK_W        = 25;
  localparam int unsigned c_KICK_H        = 28;
  localparam int unsigned c_BODY_X        = 17;
  localparam int unsigned c_BODY_Y        = 7;
  localparam int unsigned c_BODY_W        = 36;
  localparam int unsigned c_BODY_H        = 57;
  localparam int unsigned c_MAX_HEALTH    = 14;
  localparam int unsigned c_DAMAGE        = 1;
  localparam int unsigned c_FREEZE_FRAMES = 2;

  // States 3..5 are the left-facing variants; anything else faces right.
  function automatic logic faces_left(input fighter_state_e s);
    return (s == STAND_L) || (s == JUMP_L) || (s == KICK_L);
  endfunction

  // Inclusive overlap: boxes touching on an edge count as overlapping.
  function automatic logic boxes_overlap(input box_t a, input box_t b);
    return !((a.x1 < b.x0) || (b.x1 < a.x0) || (a.y1 < b.y0) || (b.y1 < a.y0));
  endfunction

endpackage
`default_nettype wire

// File: rtl/hitbox_gen.sv
`default_nettype none
// ============================================================================
// Module      : hitbox_gen
// Description : Builds the attacker's kick box and the defender's (facing-
//               mirrored) body box, registers both, and reports overlap.
// Revision    : 1.0 - initial release
// ============================================================================
module hitbox_gen
  import divekick_pkg::*;
#(
  parameter int unsigned FIGHTER_W = c_FIGHTER_W,
  parameter int unsigned FIGHTER_H = c_FIGHTER_H,
  parameter int unsigned KICK_W    = c_KICK_W,
  parameter int unsigned KICK_H    = c_KICK_H,
  parameter int unsigned BODY_X    = c_BODY_X,
  parameter int unsigned BODY_Y    = c_BODY_Y,
  parameter int unsigned BODY_W    = c_BODY_W,
  parameter int unsigned BODY_H    = c_BODY_H
) (
  input  logic           Clk,
  input  logic           Reset,
  input  fighter_state_e i_att_state,
  input  logic [9:0]     i_att_x,
  input  logic [9:0]     i_att_y,
  input  fighter_state_e i_def_state,
  input  logic [9:0]     i_def_x,
  input  logic [9:0]     i_def_y,
  output box_t           o_kick_box,
  output box_t           o_body_box,
  output logic           o_kick_valid,
  output logic           o_overlap
);

  localparam logic [10:0] c_FW      = 11'(FIGHTER_W);
  localparam logic [10:0] c_FH      = 11'(FIGHTER_H);
  localparam logic [10:0] c_KW      = 11'(KICK_W);
  localparam logic [10:0] c_KR_X0   = 11'(FIGHTER_W - KICK_W);
  localparam logic [10:0] c_KICK_Y0 = 11'(FIGHTER_H - KICK_H);
  localparam logic [10:0] c_BX_R    = 11'(BODY_X);
  localparam logic [10:0] c_BX_L    = 11'(FIGHTER_W - BODY_X - BODY_W);
  localparam logic [10:0] c_BY      = 11'(BODY_Y);
  localparam logic [10:0] c_BW      = 11'(BODY_W);
  localparam logic [10:0] c_BH      = 11'(BODY_H);

  logic [10:0] w_ax, w_ay, w_dx, w_dy, w_bx0;
  box_t        w_kick_box, w_body_box;
  logic        w_kick_valid;
  box_t        r_kick_box, r_body_box;
  logic        r_kick_valid;

  assign w_ax = {1'b0, i_att_x};
  assign w_ay = {1'b0, i_att_y};
  assign w_dx = {1'b0, i_def_x};
  assign w_dy = {1'b0, i_def_y};

  // Kick box sits at the foot on the leading edge; only the kick states own one.
  always_comb begin
    w_kick_box   = '0;
    w_kick_valid = 1'b0;
    case (i_att_state)
      KICK_R: begin
        w_kick_valid  = 1'b1;
        w_kick_box.x0 = w_ax + c_KR_X0;
        w_kick_box.x1 = w_ax + c_FW;
      end
      KICK_L: begin
        w_kick_valid  = 1'b1;
        w_kick_box.x0 = w_ax;
        w_kick_box.x1 = w_ax + c_KW;
      end
      default: ;
    endcase
    w_kick_box.y0 = w_ay + c_KICK_Y0;
    w_kick_box.y1 = w_ay + c_FH;
  end

  // Body hurtbox mirrored horizontally when the defender faces left.
  always_comb begin
    w_bx0         = w_dx + (faces_left(i_def_state) ? c_BX_L : c_BX_R);
    w_body_box    = '0;
    w_body_box.x0 = w_bx0;
    w_body_box.x1 = w_bx0 + c_BW;
    w_body_box.y0 = w_dy + c_BY;
    w_body_box.y1 = w_dy + c_BY + c_BH;
  end

  // Register both boxes every clock so the compare sees a stable snapshot.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_kick_box   <= '0;
      r_body_box   <= '0;
      r_kick_valid <= 1'b0;
    end else begin
      r_kick_box   <= w_kick_box;
      r_body_box   <= w_body_box;
      r_kick_valid <= w_kick_valid;
    end
  end

  assign o_kick_box   = r_kick_box;
  assign o_body_box   = r_body_box;
  assign o_kick_valid = r_kick_valid;
  assign o_overlap    = r_kick_valid & boxes_overlap(r_kick_box, r_body_box);

endmodule
`default_nettype wire

// File: rtl/hit_round_controller.sv
`default_nettype none
// ============================================================================
// Module      : hit_round_controller
// Description : Two-player hit detection, saturating health, post-hit freeze
//               and round winner logic for DiveKick.
// Revision    : 1.0 - initial release
// ============================================================================
module hit_round_controller
  import divekick_pkg::*;
#(
  parameter int unsigned FIGHTER_W     = c_FIGHTER_W,
  parameter int unsigned FIGHTER_H     = c_FIGHTER_H,
  parameter int unsigned KICK_W        = c_KICK_W,
  parameter int unsigned KICK_H        = c_KICK_H,
  parameter int unsigned BODY_X        = c_BODY_X,
  parameter int unsigned BODY_Y        = c_BODY_Y,
  parameter int unsigned BODY_W        = c_BODY_W,
  parameter int unsigned BODY_H        = c_BODY_H,
  parameter int unsigned MAX_HEALTH    = c_MAX_HEALTH,
  parameter int unsigned DAMAGE        = c_DAMAGE,
  parameter int unsigned FREEZE_FRAMES = c_FREEZE_FRAMES,
  parameter int unsigned HW            = $clog2(MAX_HEALTH + 1)
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           frame_clk,
  input  logic           next_round,
  input  fighter_state_e p1_state,
  input  fighter_state_e p2_state,
  input  logic [9:0]     p1_x,
  input  logic [9:0]     p1_y,
  input  logic [9:0]     p2_x,
  input  logic [9:0]     p2_y,
  output logic           Freeze,
  output logic [HW-1:0]  p1_health,
  output logic [HW-1:0]  p2_health,
  output logic           p1_hit,
  output logic           p2_hit,
  output logic           round_over,
  output logic [1:0]     winner
);

  localparam int unsigned c_CW          = (FREEZE_FRAMES > 1) ? $clog2(FREEZE_FRAMES) : 1;
  localparam logic [c_CW-1:0] c_FRZ_LAST = c_CW'(FREEZE_FRAMES - 1);
  localparam logic [HW-1:0]   c_MAX      = HW'(MAX_HEALTH);
  localparam logic [HW-1:0]   c_DMG      = HW'(DAMAGE);

  round_state_e    r_state, w_state_nxt;
  logic [c_CW-1:0] r_cnt, w_cnt_nxt;
  logic [HW-1:0]   r_p1_health, w_p1_health_nxt;
  logic [HW-1:0]   r_p2_health, w_p2_health_nxt;
  logic            r_p1_hit, w_p1_hit_nxt;
  logic            r_p2_hit, w_p2_hit_nxt;
  winner_e         r_winner, w_winner_nxt;
  logic            r_frame_q, r_frame_d;
  logic            w_tick;
  logic            w_hit1, w_hit2;

  box_t            w_k1_box, w_b2_box, w_k2_box, w_b1_box;
  logic            w_k1_valid, w_k2_valid;
  logic            w_unused_boxes;

  // Health drops by DAMAGE but never below zero.
  function automatic logic [HW-1:0] sat_dec(input logic [HW-1:0] h);
    return (h > c_DMG) ? (h - c_DMG) : '0;
  endfunction

  // P1 attacking P2's body.
  hitbox_gen #(
    .FIGHTER_W (FIGHTER_W), .FIGHTER_H (FIGHTER_H),
    .KICK_W    (KICK_W),    .KICK_H    (KICK_H),
    .BODY_X    (BODY_X),    .BODY_Y    (BODY_Y),
    .BODY_W    (BODY_W),    .BODY_H    (BODY_H)
  ) u_p1_attack (
    .Clk          (Clk),
    .Reset        (Reset),
    .i_att_state  (p1_state),
    .i_att_x      (p1_x),
    .i_att_y      (p1_y),
    .i_def_state  (p2_state),
    .i_def_x      (p2_x),
    .i_def_y      (p2_y),
    .o_kick_box   (w_k1_box),
    .o_body_box   (w_b2_box),
    .o_kick_valid (w_k1_valid),
    .o_overlap    (w_hit1)
  );

  // P2 attacking P1's body.
  hitbox_gen #(
    .FIGHTER_W (FIGHTER_W), .FIGHTER_H (FIGHTER_H),
    .KICK_W    (KICK_W),    .KICK_H    (KICK_H),
    .BODY_X    (BODY_X),    .BODY_Y    (BODY_Y),
    .BODY_W    (BODY_W),    .BODY_H    (BODY_H)
  ) u_p2_attack (
    .Clk          (Clk),
    .Reset        (Reset),
    .i_att_state  (p2_state),
    .i_att_x      (p2_x),
    .i_att_y      (p2_y),
    .i_def_state  (p1_state),
    .i_def_x      (p1_x),
    .i_def_y      (p1_y),
    .o_kick_box   (w_k2_box),
    .o_body_box   (w_b1_box),
    .o_kick_valid (w_k2_valid),
    .o_overlap    (w_hit2)
  );

  // Box geometry is exported by the sub-module for debug taps; the round
  // logic only needs the overlap result.
  assign w_unused_boxes = ^{w_k1_box, w_b2_box, w_k2_box, w_b1_box, w_k1_valid, w_k2_valid};

  // Sample the frame strobe and keep a delayed copy for rising-edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_q <= 1'b0;
      r_frame_d <= 1'b0;
    end else begin
      r_frame_q <= frame_clk;
      r_frame_d <= r_frame_q;
    end
  end

  assign w_tick = r_frame_q & ~r_frame_d;

  // Next-state and datapath updates for the FIGHT / FREEZE / ROUND_OVER flow.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_p1_health_nxt = r_p1_health;
    w_p2_health_nxt = r_p2_health;
    w_p1_hit_nxt    = 1'b0;
    w_p2_hit_nxt    = 1'b0;
    w_winner_nxt    = r_winner;
    case (r_state)
      ST_FIGHT: begin
        if (w_tick && (w_hit1 || w_hit2)) begin
          w_p1_hit_nxt = w_hit1;
          w_p2_hit_nxt = w_hit2;
          if (w_hit1) w_p2_health_nxt = sat_dec(r_p2_health);
          if (w_hit2) w_p1_health_nxt = sat_dec(r_p1_health);
          w_cnt_nxt   = '0;
          w_state_nxt = ST_FREEZE;
        end
      end
      ST_FREEZE: begin
        if (w_tick) begin
          if (r_cnt == c_FRZ_LAST) begin
            if ((r_p1_health == '0) || (r_p2_health == '0)) begin
              w_state_nxt = ST_ROUND_OVER;
              if ((r_p1_health == '0) && (r_p2_health == '0)) w_winner_nxt = WIN_DRAW;
              else if (r_p2_health == '0)                     w_winner_nxt = WIN_P1;
              else                                            w_winner_nxt = WIN_P2;
            end else begin
              w_state_nxt = ST_FIGHT;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_ROUND_OVER: begin
        if (next_round) begin
          w_p1_health_nxt = c_MAX;
          w_p2_health_nxt = c_MAX;
          w_winner_nxt    = WIN_NONE;
          w_cnt_nxt       = '0;
          w_state_nxt     = ST_FIGHT;
        end
      end
      default: begin
        w_state_nxt = ST_FIGHT;
      end
    endcase
  end

  // State, counter, health and pulse registers; reset overrides everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_FIGHT;
      r_cnt       <= '0;
      r_p1_health <= c_MAX;
      r_p2_health <= c_MAX;
      r_p1_hit    <= 1'b0;
      r_p2_hit    <= 1'b0;
      r_winner    <= WIN_NONE;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_p1_health <= w_p1_health_nxt;
      r_p2_health <= w_p2_health_nxt;
      r_p1_hit    <= w_p1_hit_nxt;
      r_p2_hit    <= w_p2_hit_nxt;
      r_winner    <= w_winner_nxt;
    end
  end

  assign Freeze     = (r_state != ST_FIGHT);
  assign round_over = (r_state == ST_ROUND_OVER);
  assign winner     = r_winner;
  assign p1_health  = r_p1_health;
  assign p2_health  = r_p2_health;
  assign p1_hit     = r_p1_hit;
  assign p2_hit     = r_p2_hit;

endmodule
`default_nettype wire

// File: tb/tb_hit_round_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hit_round_controller
// Description : Directed, table-driven bench for hit_round_controller. A
//               second instance with a tall kick box and one hit point
//               exercises the simultaneous-hit (trade) path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hit_round_controller;
  import divekick_pkg::*;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           frame_clk;
  logic           next_round;
  fighter_state_e p1_state, p2_state;
  logic [9:0]     p1_x, p1_y, p2_x, p2_y;

  logic           Freeze, p1_hit, p2_hit, round_over;
  logic [3:0]     p1_health, p2_health;
  logic [1:0]     winner;

  logic           t_freeze, t_p1_hit, t_p2_hit, t_round_over;
  logic [0:0]     t_p1_health, t_p2_health;
  logic [1:0]     t_winner;

  int n_cmp = 0;
  int n_bad = 0;

  // Values captured by frame_tick one cycle after the tick is acted on.
  logic s_p1hit, s_p2hit, s_t_p1hit, s_t_p2hit, s_late;

  hit_round_controller dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .next_round (next_round),
    .p1_state   (p1_state),
    .p2_state   (p2_state),
    .p1_x       (p1_x),
    .p1_y       (p1_y),
    .p2_x       (p2_x),
    .p2_y       (p2_y),
    .Freeze     (Freeze),
    .p1_health  (p1_health),
    .p2_health  (p2_health),
    .p1_hit     (p1_hit),
    .p2_hit     (p2_hit),
    .round_over (round_over),
    .winner     (winner)
  );

  hit_round_controller #(.KICK_H(60), .MAX_HEALTH(1)) dut_trade (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .next_round (next_round),
    .p1_state   (p1_state),
    .p2_state   (p2_state),
    .p1_x       (p1_x),
    .p1_y       (p1_y),
    .p2_x       (p2_x),
    .p2_y       (p2_y),
    .Freeze     (t_freeze),
    .p1_health  (t_p1_health),
    .p2_health  (t_p2_health),
    .p1_hit     (t_p1_hit),
    .p2_hit     (t_p2_hit),
    .round_over (t_round_over),
    .winner     (t_winner)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic set_pos(input fighter_state_e s1, input logic [9:0] x1, input logic [9:0] y1,
                         input fighter_state_e s2, input logic [9:0] x2, input logic [9:0] y2);
    @(negedge Clk);
    p1_state = s1; p1_x = x1; p1_y = y1;
    p2_state = s2; p2_x = x2; p2_y = y2;
    repeat (3) @(posedge Clk);
  endtask

  // One frame strobe. The edge is seen at the first clock, acted on at the
  // second; outputs are sampled just after that, and again one clock later.
  task automatic frame_tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    s_p1hit   = p1_hit;
    s_p2hit   = p2_hit;
    s_t_p1hit = t_p1_hit;
    s_t_p2hit = t_p2_hit;
    @(posedge Clk);
    #1;
    s_late = p1_hit | p2_hit | t_p1_hit | t_p2_hit;
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic pulse_next_round();
    @(negedge Clk);
    next_round = 1'b1;
    @(negedge Clk);
    next_round = 1'b0;
    #1;
  endtask

  typedef struct packed {
    fighter_state_e s1;
    logic [9:0]     x1;
    logic [9:0]     y1;
    fighter_state_e s2;
    logic [9:0]     x2;
    logic [9:0]     y2;
    logic           e1;
    logic           e2;
  } vec_t;

  vec_t vecs [13];
  int   m_p1, m_p2, hits, ticks;
  logic exp_frz;

  initial begin
    vecs[0]  = '{KICK_R, 10'd100, 10'd250, STAND_L, 10'd150, 10'd300, 1'b1, 1'b0};
    vecs[1]  = '{KICK_R, 10'd100, 10'd300, STAND_L, 10'd300, 10'd300, 1'b0, 1'b0};
    vecs[2]  = '{KICK_R, 10'd100, 10'd250, STAND_L, 10'd153, 10'd300, 1'b1, 1'b0};
    vecs[3]  = '{KICK_R, 10'd100, 10'd250, STAND_L, 10'd154, 10'd300, 1'b0, 1'b0};
    vecs[4]  = '{KICK_R, 10'd100, 10'd287, STAND_L, 10'd150, 10'd300, 1'b1, 1'b0};
    vecs[5]  = '{KICK_R, 10'd100, 10'd288, STAND_L, 10'd150, 10'd300, 1'b0, 1'b0};
    vecs[6]  = '{JUMP,   10'd100, 10'd250, STAND_L, 10'd150, 10'd300, 1'b0, 1'b0};
    vecs[7]  = '{KICK_R, 10'd100, 10'd250, STAND,   10'd155, 10'd300, 1'b1, 1'b0};
    vecs[8]  = '{KICK_R, 10'd100, 10'd250, STAND_L, 10'd155, 10'd300, 1'b0, 1'b0};
    vecs[9]  = '{STAND,  10'd160, 10'd300, KICK_L,  10'd200, 10'd250, 1'b0, 1'b1};
    vecs[10] = '{STAND,  10'd147, 10'd300, KICK_L,  10'd200, 10'd250, 1'b0, 1'b1};
    vecs[11] = '{STAND,  10'd146, 10'd300, KICK_L,  10'd200, 10'd250, 1'b0, 1'b0};
    vecs[12] = '{KICK_L, 10'd100, 10'd250, STAND,   10'd60,  10'd300, 1'b1, 1'b0};

    Reset = 1'b1; frame_clk = 1'b0; next_round = 1'b0;
    p1_state = STAND; p1_x = 10'd0;   p1_y = 10'd300;
    p2_state = STAND; p2_x = 10'd500; p2_y = 10'd300;

    // Reset state
    do_reset();
    #1;
    check("reset_p1_health", p1_health, 14);
    check("reset_p2_health", p2_health, 14);
    check("reset_freeze", Freeze, 0);
    check("reset_round_over", round_over, 0);
    check("reset_winner", winner, 0);
    check("reset_pulses", p1_hit | p2_hit, 0);

    // Table: one tick per geometry case, then ride out any freeze.
    m_p1 = 14; m_p2 = 14;
    for (int i = 0; i < 13; i++) begin
      set_pos(vecs[i].s1, vecs[i].x1, vecs[i].y1, vecs[i].s2, vecs[i].x2, vecs[i].y2);
      frame_tick();
      check($sformatf("vec%0d_p1_hit", i), s_p1hit, vecs[i].e1);
      check($sformatf("vec%0d_p2_hit", i), s_p2hit, vecs[i].e2);
      check($sformatf("vec%0d_main_pulse_width", i), int'(p1_hit | p2_hit), 0);
      if (vecs[i].e1) m_p2 = m_p2 - 1;
      if (vecs[i].e2) m_p1 = m_p1 - 1;
      check($sformatf("vec%0d_p1_health", i), p1_health, m_p1);
      check($sformatf("vec%0d_p2_health", i), p2_health, m_p2);
      exp_frz = vecs[i].e1 | vecs[i].e2;
      check($sformatf("vec%0d_freeze", i), Freeze, exp_frz);
      if (exp_frz) begin
        frame_tick();
        check($sformatf("vec%0d_frz1_pulse", i), int'(s_p1hit | s_p2hit), 0);
        check($sformatf("vec%0d_frz1_freeze", i), Freeze, 1);
        frame_tick();
        check($sformatf("vec%0d_frz2_pulse", i), int'(s_p1hit | s_p2hit), 0);
        check($sformatf("vec%0d_frz2_freeze", i), Freeze, 0);
      end
    end

    // Miss held over ten ticks
    do_reset();
    set_pos(KICK_R, 10'd100, 10'd300, STAND_L, 10'd300, 10'd300);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      frame_tick();
      if (s_p1hit | s_p2hit) hits++;
    end
    check("miss_pulses", hits, 0);
    check("miss_p2_health", p2_health, 14);
    check("miss_freeze", Freeze, 0);

    // Trade on the tall-kick, one-hit-point instance
    do_reset();
    set_pos(KICK_R, 10'd100, 10'd300, KICK_L, 10'd150, 10'd300);
    frame_tick();
    check("trade_p1_hit", s_t_p1hit, 1);
    check("trade_p2_hit", s_t_p2hit, 1);
    check("trade_main_no_hit", int'(s_p1hit | s_p2hit), 0);
    check("trade_pulse_width", s_late, 0);
    check("trade_p1_health", t_p1_health, 0);
    check("trade_p2_health", t_p2_health, 0);
    frame_tick();
    check("trade_mid_freeze", t_freeze, 1);
    check("trade_mid_round_over", t_round_over, 0);
    frame_tick();
    check("trade_round_over", t_round_over, 1);
    check("trade_winner", t_winner, 3);
    check("trade_freeze_held", t_freeze, 1);

    // P1 wins by 14 hits, then restart
    do_reset();
    set_pos(KICK_R, 10'd100, 10'd250, STAND_L, 10'd150, 10'd300);
    hits = 0; ticks = 0;
    while (!round_over && ticks < 60) begin
      frame_tick();
      if (s_p1hit) hits++;
      ticks++;
    end
    check("ko_round_over", round_over, 1);
    check("ko_hit_count", hits, 14);
    check("ko_p2_health", p2_health, 0);
    check("ko_p1_health", p1_health, 14);
    check("ko_winner", winner, 1);
    check("ko_freeze", Freeze, 1);
    frame_tick();
    check("ko_hold_no_pulse", int'(s_p1hit | s_p2hit), 0);
    check("ko_hold_round_over", round_over, 1);
    pulse_next_round();
    check("restart_p1_health", p1_health, 14);
    check("restart_p2_health", p2_health, 14);
    check("restart_freeze", Freeze, 0);
    check("restart_round_over", round_over, 0);
    check("restart_winner", winner, 0);

    // next_round in FREEZE and in FIGHT is ignored
    frame_tick();
    check("nr_hit", s_p1hit, 1);
    pulse_next_round();
    check("nr_freeze_health", p2_health, 13);
    check("nr_freeze_still", Freeze, 1);
    frame_tick();
    frame_tick();
    check("nr_back_to_fight", Freeze, 0);
    pulse_next_round();
    check("nr_fight_health", p2_health, 13);
    check("nr_fight_round_over", round_over, 0);

    // Reset mid-FREEZE, coincident with a tick
    set_pos(KICK_R, 10'd100, 10'd250, STAND_L, 10'd150, 10'd300);
    frame_tick();
    check("rst_pre_freeze", Freeze, 1);
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("rst_tick_freeze", Freeze, 0);
    check("rst_tick_pulse", int'(p1_hit | p2_hit), 0);
    check("rst_tick_p2_health", p2_health, 14);
    check("rst_tick_p1_health", p1_health, 14);
    @(negedge Clk);
    frame_clk = 1'b0;
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_after_pulse", int'(p1_hit | p2_hit), 0);
    check("rst_after_freeze", Freeze, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
